// File: rtl/uart_cmd_parser_if.sv
// Rx/Tx FIFO handshake and register-write bus of the UART command parser.
// master = parser side, slave = FIFO / register-file side.
interface uart_cmd_parser_if #(
    parameter int DBITS = 8
);
    logic             rx_empty;
    logic [DBITS-1:0] read_data;
    logic             read_uart;
    logic             tx_full;
    logic             write_uart;
    logic [DBITS-1:0] write_data;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [DBITS-1:0] wr_data;

    modport master (
        input  rx_empty, read_data, tx_full,
        output read_uart, write_uart, write_data, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_empty, read_data, tx_full,
        input  read_uart, write_uart, write_data, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Framed register-write command parser: SYNC(A5) ADDR LEN payload CHK -> wr beats + ACK/NAK byte.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter int DBITS          = 8,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    uart_cmd_parser_if.master bus,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              busy
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [DBITS-1:0] SYNC_B    = DBITS'(8'hA5);
    localparam logic [DBITS-1:0] ACK_B     = DBITS'(8'h06);
    localparam logic [DBITS-1:0] NAK_B     = DBITS'(8'h15);
    localparam logic [DBITS-1:0] MAX_LEN_B = DBITS'(MAX_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_LEN    = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    logic [2:0]       state, state_nxt;
    logic [DBITS-1:0] addr_q, len_q, xor_q;
    logic [AW-1:0]    idx_q;
    logic [DBITS-1:0] buf_q [MAX_LEN];
    logic             ack_q;
    logic             pop;
    logic             rx_state;
    logic             last_idx;
    logic             tmo_hit;

    // States that consume the Rx FIFO; COMMIT/RESP leave bytes queued.
    assign rx_state = (state == S_IDLE) || (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHK);
    assign pop           = !RST && rx_state && !bus.rx_empty;
    assign bus.read_uart = pop;

    // idx_q is the payload index in DATA and the beat index in COMMIT.
    assign last_idx = (DBITS'(idx_q) == (len_q - DBITS'(1)));

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        waiting;

    assign waiting = rx_state && (state != S_IDLE);
    assign tmo_hit = waiting && !pop && (tmo_q >= 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || pop || !waiting) tmo_q <= '0;
        else                        tmo_q <= tmo_q + 32'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pop && bus.read_data == SYNC_B) state_nxt = S_ADDR;
            S_ADDR:   if (pop) state_nxt = S_LEN;
            S_LEN: begin
                if (pop) begin
                    if (bus.read_data == '0)             state_nxt = S_CHK;
                    else if (bus.read_data > MAX_LEN_B)  state_nxt = S_RESP;
                    else                                 state_nxt = S_DATA;
                end
            end
            S_DATA:   if (pop && last_idx) state_nxt = S_CHK;
            S_CHK:    if (pop) state_nxt = (bus.read_data == xor_q) ? S_COMMIT : S_RESP;
            S_COMMIT: if (len_q == '0 || last_idx) state_nxt = S_RESP;
            S_RESP:   if (!bus.tx_full) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (tmo_hit) state_nxt = S_RESP;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            xor_q          <= '0;
            idx_q          <= '0;
            ack_q          <= 1'b0;
            busy           <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            bus.write_uart <= 1'b0;
            bus.write_data <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            state          <= state_nxt;
            busy           <= (state_nxt != S_IDLE);
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            bus.write_uart <= 1'b0;
            bus.wr_en      <= 1'b0;
            case (state)
                S_IDLE: begin
                    xor_q <= '0;
                    idx_q <= '0;
                    ack_q <= 1'b0;
                end
                S_ADDR: if (pop) begin
                    addr_q <= bus.read_data;
                    xor_q  <= xor_q ^ bus.read_data;
                end
                S_LEN: if (pop) begin
                    len_q <= bus.read_data;
                    xor_q <= xor_q ^ bus.read_data;
                end
                S_DATA: if (pop) begin
                    xor_q <= xor_q ^ bus.read_data;
                    idx_q <= idx_q + AW'(1);
                end
                S_CHK: if (pop) begin
                    ack_q <= (bus.read_data == xor_q);
                    idx_q <= '0;
                end
                S_COMMIT: if (len_q != '0) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= 8'(addr_q) + 8'(idx_q);
                    bus.wr_data <= buf_q[idx_q];
                    idx_q       <= idx_q + AW'(1);
                end
                S_RESP: if (!bus.tx_full) begin
                    bus.write_uart <= 1'b1;
                    bus.write_data <= ack_q ? ACK_B : NAK_B;
                    frame_ok       <= ack_q;
                    frame_err      <= !ack_q;
                end
                default: ;
            endcase
        end
    end

    // Payload buffer holds data only; no reset needed since COMMIT reads only written slots.
    always_ff @(posedge CLK) begin
        if (state == S_DATA && pop) buf_q[idx_q] <= bus.read_data;
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed vector table, multi-cycle corner sequences,
// and a randomized frame stream checked against a frame-level reference model.
module tb_uart_cmd_parser;
    localparam int MAXL = 16;
    localparam int TMO  = 100;
    localparam logic [9:0] R_ACK = {1'b1, 1'b0, 8'h06};
    localparam logic [9:0] R_NAK = {1'b0, 1'b1, 8'h15};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic frame_ok, frame_err, busy;

    uart_cmd_parser_if #(.DBITS(8)) bus ();

    uart_cmd_parser #(.DBITS(8), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  rx_q[$];
    logic [15:0] got_wr[$];
    int          got_cyc[$];
    logic [9:0]  got_resp[$];
    int          stray = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        int          n;
        logic [7:0]  b [10];
        int          nwr;
        logic [15:0] wr [2];
        logic [9:0]  resp;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clear_caps();
        got_wr.delete();
        got_cyc.delete();
        got_resp.delete();
    endtask

    task automatic wait_resp(input int n, input int budget, input string name);
        int t = 0;
        while (got_resp.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        chk(name, 32'(got_resp.size() >= n), 32'd1);
    endtask

    // FIFO model and output capture; FIFO pops happen on edges where read_uart was high.
    initial begin
        bit pop;
        bus.rx_empty  = 1'b1;
        bus.read_data = 8'h00;
        forever begin
            @(negedge CLK);
            pop = bus.read_uart;
            if (bus.wr_en) begin
                got_wr.push_back({bus.wr_addr, bus.wr_data});
                got_cyc.push_back(cyc);
            end
            if (bus.write_uart) got_resp.push_back({frame_ok, frame_err, bus.write_data});
            else if (frame_ok || frame_err) stray++;
            cyc++;
            @(posedge CLK);
            #1;
            if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
            bus.rx_empty  = (rx_q.size() == 0);
            bus.read_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    end

    task automatic run_vec(input int i);
        clear_caps();
        for (int k = 0; k < vt[i].n; k++) rx_q.push_back(vt[i].b[k]);
        wait_resp(1, 200, $sformatf("v%0d_resp_seen", i));
        tick(4);
        chk($sformatf("v%0d_resp_cnt", i), got_resp.size(), 1);
        if (got_resp.size() != 0) chk($sformatf("v%0d_resp", i), got_resp[0], vt[i].resp);
        chk($sformatf("v%0d_wr_cnt", i), got_wr.size(), vt[i].nwr);
        for (int k = 0; k < vt[i].nwr && k < got_wr.size(); k++)
            chk($sformatf("v%0d_wr%0d", i, k), got_wr[k], vt[i].wr[k]);
        if (vt[i].nwr == 2 && got_cyc.size() == 2)
            chk($sformatf("v%0d_consec", i), got_cyc[1] - got_cyc[0], 1);
        chk($sformatf("v%0d_idle", i), busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  exp_q[$];
        logic [15:0] exp_wr[$];
        logic [9:0]  exp_resp[$];
        int t;

        vt[0] = '{6, '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 0, 0, 0, 0}, 2, '{16'h1011, 16'h1122}, R_ACK};
        vt[1] = '{6, '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20, 0, 0, 0, 0}, 0, '{16'h0, 16'h0}, R_NAK};
        vt[2] = '{8, '{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, 0, 0}, 2, '{16'hFFAA, 16'h00BB}, R_ACK};
        vt[3] = '{3, '{8'hA5, 8'h10, 8'h11, 0, 0, 0, 0, 0, 0, 0}, 0, '{16'h0, 16'h0}, R_NAK};
        vt[4] = vt[0];
        vt[5] = '{4, '{8'hA5, 8'h30, 8'h00, 8'h30, 0, 0, 0, 0, 0, 0}, 0, '{16'h0, 16'h0}, R_ACK};
        vt[6] = '{5, '{8'hA5, 8'h7F, 8'h01, 8'h5A, 8'h24, 0, 0, 0, 0, 0}, 1, '{16'h7F5A, 16'h0}, R_ACK};

        bus.tx_full = 1'b0;
        RST = 1'b1;
        rx_q.push_back(8'hA5);
        tick(3);
        chk("rst_read_uart",  bus.read_uart,  1'b0);
        chk("rst_write_uart", bus.write_uart, 1'b0);
        chk("rst_wr_en",      bus.wr_en,      1'b0);
        chk("rst_frame_ok",   frame_ok,       1'b0);
        chk("rst_frame_err",  frame_err,      1'b0);
        chk("rst_busy",       busy,           1'b0);
        chk("rst_write_data", bus.write_data, 8'h00);
        chk("rst_wr_addr",    bus.wr_addr,    8'h00);
        chk("rst_wr_data",    bus.wr_data,    8'h00);
        rx_q.delete();
        tick(2);
        RST = 1'b0;
        tick(2);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Response held off by tx_full; a trailing byte must stay in the Rx FIFO.
        clear_caps();
        bus.tx_full = 1'b1;
        for (int k = 0; k < 6; k++) rx_q.push_back(vt[0].b[k]);
        rx_q.push_back(8'h00);
        tick(60);
        chk("txf_no_push",   got_resp.size(), 0);
        chk("txf_rx_kept",   rx_q.size(),     1);
        chk("txf_wr_cnt",    got_wr.size(),   2);
        chk("txf_busy",      busy,            1'b1);
        bus.tx_full = 1'b0;
        wait_resp(1, 20, "txf_resp_seen");
        tick(5);
        chk("txf_resp_cnt",  got_resp.size(), 1);
        if (got_resp.size() != 0) chk("txf_resp", got_resp[0], R_ACK);
        chk("txf_rx_drained", rx_q.size(),    0);

        // Reset asserted while in DATA abandons the frame silently.
        clear_caps();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h10); rx_q.push_back(8'h03);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        tick(10);
        chk("mid_busy", busy, 1'b1);
        RST = 1'b1;
        tick(2);
        chk("mid_rst_busy",  busy,          1'b0);
        chk("mid_rst_rdu",   bus.read_uart, 1'b0);
        RST = 1'b0;
        tick(5);
        chk("mid_no_wr",   got_wr.size(),   0);
        chk("mid_no_resp", got_resp.size(), 0);
        chk("mid_idle",    busy,            1'b0);
        run_vec(0);

`ifdef UART_CMD_TIMEOUT_EN
        clear_caps();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h10);
        tick(90);
        chk("tmo_not_early", got_resp.size(), 0);
        wait_resp(1, 100, "tmo_resp_seen");
        tick(3);
        if (got_resp.size() != 0) chk("tmo_resp", got_resp[0], R_NAK);
        chk("tmo_no_wr", got_wr.size(), 0);
        chk("tmo_idle",  busy, 1'b0);
`endif

        // Random frame stream; expectations come from how each frame was built.
        clear_caps();
        for (int f = 0; f < 40; f++) begin
            int ng, kind, len;
            logic [7:0] addr, x, g, d;
            ng = $urandom_range(0, 3);
            for (int k = 0; k < ng; k++) begin
                g = 8'($urandom_range(0, 254));
                if (g >= 8'hA5) g = g + 8'd1;
                exp_q.push_back(g);
            end
            kind = $urandom_range(0, 9);
            addr = 8'($urandom_range(0, 255));
            if (kind >= 8) begin
                len = $urandom_range(MAXL + 1, 255);
                exp_q.push_back(8'hA5); exp_q.push_back(addr); exp_q.push_back(8'(len));
                exp_resp.push_back(R_NAK);
            end else begin
                len = (f % 8 == 0) ? MAXL : $urandom_range(0, MAXL);
                exp_q.push_back(8'hA5); exp_q.push_back(addr); exp_q.push_back(8'(len));
                x = addr ^ 8'(len);
                for (int k = 0; k < len; k++) begin
                    d = 8'($urandom_range(0, 255));
                    exp_q.push_back(d);
                    x = x ^ d;
                    if (kind < 6) exp_wr.push_back({addr + 8'(k), d});
                end
                if (kind < 6) begin
                    exp_q.push_back(x);
                    exp_resp.push_back(R_ACK);
                end else begin
                    exp_q.push_back(x ^ 8'($urandom_range(1, 255)));
                    exp_resp.push_back(R_NAK);
                end
            end
        end
        foreach (exp_q[k]) rx_q.push_back(exp_q[k]);
        t = 0;
        while (got_resp.size() < exp_resp.size() && t < 6000) begin
            bus.tx_full = ($urandom_range(0, 3) == 0);
            tick(1);
            t++;
        end
        bus.tx_full = 1'b0;
        tick(5);
        chk("rnd_resp_cnt", got_resp.size(), exp_resp.size());
        chk("rnd_wr_cnt",   got_wr.size(),   exp_wr.size());
        for (int k = 0; k < exp_resp.size() && k < got_resp.size(); k++)
            chk($sformatf("rnd_resp%0d", k), got_resp[k], exp_resp[k]);
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++)
            chk($sformatf("rnd_wr%0d", k), got_wr[k], exp_wr[k]);
        chk("rnd_rx_drained", rx_q.size(), 0);
        chk("stray_pulses",   stray,       0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
